// File: rtl/mem_access_unit_if.sv
// Request/response channel plus RAM strobe port of the load/store initiator.
// master = the initiating unit, slave = the execute stage / RAM side.
interface mem_access_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqBase;
  logic [15:0] reqOffset;
  logic [31:0] reqWData;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspData;
  logic        rspError;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;

  modport master (
    input  reqValid, reqWrite, reqBase, reqOffset, reqWData, rspReady, memRData,
    output reqReady, rspValid, rspData, rspError, memRead, memWrite, memAddr, memWData
  );

  modport slave (
    output reqValid, reqWrite, reqBase, reqOffset, reqWData, rspReady, memRData,
    input  reqReady, rspValid, rspData, rspError, memRead, memWrite, memAddr, memWData
  );
endinterface

// File: rtl/mem_access_unit.sv
// Word load/store initiator: forms/checks the effective address, strobes the RAM,
// waits READ_LATENCY for loads and returns one response per request.
module mem_access_unit #(
  parameter int MEM_WORDS    = 256,
  parameter int READ_LATENCY = 1
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [3:0] CNT_LAST = 4'(READ_LATENCY - 1);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_error;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_cnt;

  logic [31:0] w_ea;
  logic        w_err;

  // Address arithmetic wraps mod 2^32; only alignment and range flag an error.
  assign w_ea  = bus.reqBase + {{16{bus.reqOffset[15]}}, bus.reqOffset};
  assign w_err = (w_ea[1:0] != 2'b00) || ({2'b00, w_ea[31:2]} >= 32'(MEM_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // reqReady comes up one edge after reset release, then stays up in IDLE.
          if (!r_req_ready) begin
            r_req_ready <= 1'b1;
          end else if (bus.reqValid) begin
            r_req_ready <= 1'b0;
            r_mem_addr  <= {2'b00, w_ea[31:2]};
            r_mem_wdata <= bus.reqWData;
            if (w_err) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
              r_rsp_data  <= '0;
            end else if (bus.reqWrite) begin
              r_state     <= WRITE;
              r_mem_write <= 1'b1;
            end else begin
              r_state    <= READ;
              r_mem_read <= 1'b1;
              r_cnt      <= '0;
            end
          end
        end
        WRITE: begin
          r_mem_write <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_error <= 1'b0;
          r_rsp_data  <= '0;
          r_state     <= RESP;
        end
        READ: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == CNT_LAST) begin
            r_mem_read  <= 1'b0;
            r_rsp_data  <= bus.memRData;
            r_rsp_error <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rspReady) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.reqReady = r_req_ready;
  assign bus.rspValid = r_rsp_valid;
  assign bus.rspData  = r_rsp_data;
  assign bus.rspError = r_rsp_error;
  assign bus.memRead  = r_mem_read;
  assign bus.memWrite = r_mem_write;
  assign bus.memAddr  = r_mem_addr;
  assign bus.memWData = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: three instances (L=1,3,4) share one RAM model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:255];

  mem_access_unit_if if1 ();
  mem_access_unit_if if3 ();
  mem_access_unit_if if4 ();

  mem_access_unit #(.MEM_WORDS(256), .READ_LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mem_access_unit #(.MEM_WORDS(256), .READ_LATENCY(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  mem_access_unit #(.MEM_WORDS(256), .READ_LATENCY(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  assign if1.memRData = mem[if1.memAddr[7:0]];
  assign if3.memRData = mem[if3.memAddr[7:0]];
  assign if4.memRData = mem[if4.memAddr[7:0]];

  always @(posedge clk) begin
    if (if1.memWrite) mem[if1.memAddr[7:0]] <= if1.memWData;
    if (if3.memWrite) mem[if3.memAddr[7:0]] <= if3.memWData;
    if (if4.memWrite) mem[if4.memAddr[7:0]] <= if4.memWData;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive a request on u1; returns at the negedge of cycle E0+1.
  task automatic issue1(input logic w, input logic [31:0] b, input logic [15:0] o,
                        input logic [31:0] d);
    if1.reqValid = 1'b1; if1.reqWrite = w; if1.reqBase = b; if1.reqOffset = o; if1.reqWData = d;
    @(posedge clk);
    @(negedge clk);
    if1.reqValid = 1'b0;
  endtask

  // Store on u1 and drain the response, with a bounded wait.
  task automatic store1(input logic [31:0] b, input logic [15:0] o, input logic [31:0] d);
    int c;
    if1.rspReady = 1'b1;
    issue1(1'b1, b, o, d);
    c = 0;
    while (!if1.rspValid && c < 10) begin @(negedge clk); c++; end
    n_cmp++;
    if (c >= 10) begin n_bad++; $display("FAIL store1_timeout got no rspValid exp rspValid within 10"); end
    @(negedge clk);
    if1.rspReady = 1'b0;
  endtask

  task automatic test_reset;
    if1.reqValid = 1'b1; if1.reqWrite = 1'b0; if1.reqBase = 32'd16; if1.reqOffset = 16'd4;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if1.reqReady, if1.rspValid, if1.rspError, if1.memRead, if1.memWrite} !== 5'b0) begin
      n_bad++; $display("FAIL rst_flags got %b exp 00000",
        {if1.reqReady, if1.rspValid, if1.rspError, if1.memRead, if1.memWrite});
    end
    n_cmp++;
    if ({if1.memAddr, if1.memWData, if1.rspData} !== 96'd0) begin
      n_bad++; $display("FAIL rst_data got %h/%h/%h exp 0", if1.memAddr, if1.memWData, if1.rspData);
    end
    rst_n = 1'b1;
    if1.reqValid = 1'b0;
    #1;
    n_cmp++;
    if (if1.reqReady !== 1'b0) begin n_bad++; $display("FAIL rst_ready_pre got %b exp 0", if1.reqReady); end
    @(negedge clk);
    n_cmp++;
    if (if1.reqReady !== 1'b1) begin n_bad++; $display("FAIL rst_ready_post got %b exp 1", if1.reqReady); end
  endtask

  task automatic test_store_load;
    if1.rspReady = 1'b0;
    issue1(1'b1, 32'd16, 16'd4, 32'd99);
    n_cmp++;
    if ({if1.memWrite, if1.memRead, if1.rspValid, if1.reqReady} !== 4'b1000) begin
      n_bad++; $display("FAIL st_strobe got %b exp 1000", {if1.memWrite, if1.memRead, if1.rspValid, if1.reqReady});
    end
    n_cmp++;
    if (if1.memAddr !== 32'd5 || if1.memWData !== 32'd99) begin
      n_bad++; $display("FAIL st_bus got addr %0d data %0d exp addr 5 data 99", if1.memAddr, if1.memWData);
    end
    @(negedge clk);
    n_cmp++;
    if ({if1.memWrite, if1.rspValid, if1.rspError} !== 3'b010 || if1.rspData !== 32'd0) begin
      n_bad++; $display("FAIL st_rsp got w%b v%b e%b d%h exp w0 v1 e0 d0",
        if1.memWrite, if1.rspValid, if1.rspError, if1.rspData);
    end
    if1.rspReady = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({if1.rspValid, if1.reqReady} !== 2'b01) begin
      n_bad++; $display("FAIL st_done got %b exp 01", {if1.rspValid, if1.reqReady});
    end
    // Load back with rspReady already high.
    issue1(1'b0, 32'd16, 16'd4, 32'd0);
    n_cmp++;
    if ({if1.memRead, if1.memWrite, if1.rspValid} !== 3'b100 || if1.memAddr !== 32'd5) begin
      n_bad++; $display("FAIL ld_strobe got r%b w%b v%b addr %0d exp r1 w0 v0 addr 5",
        if1.memRead, if1.memWrite, if1.rspValid, if1.memAddr);
    end
    @(negedge clk);
    n_cmp++;
    if ({if1.memRead, if1.rspValid, if1.rspError} !== 3'b010 || if1.rspData !== 32'd99) begin
      n_bad++; $display("FAIL ld_rsp got r%b v%b e%b d%0d exp r0 v1 e0 d99",
        if1.memRead, if1.rspValid, if1.rspError, if1.rspData);
    end
    @(negedge clk);
    n_cmp++;
    if ({if1.rspValid, if1.reqReady} !== 2'b01) begin
      n_bad++; $display("FAIL ld_done got %b exp 01", {if1.rspValid, if1.reqReady});
    end
    if1.rspReady = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc;
    acc = 0;
    if1.rspReady = 1'b1;
    if1.reqValid = 1'b1; if1.reqWrite = 1'b0; if1.reqBase = 32'd16; if1.reqOffset = 16'd4;
    for (int i = 0; i < 6; i++) begin
      if (if1.reqValid && if1.reqReady) acc++;
      @(negedge clk);
    end
    if1.reqValid = 1'b0;
    n_cmp++;
    if (acc !== 2) begin n_bad++; $display("FAIL b2b_accepts got %0d exp 2 in 6 edges", acc); end
    @(negedge clk);
    n_cmp++;
    if (if1.reqReady !== 1'b1) begin n_bad++; $display("FAIL b2b_idle got %b exp 1", if1.reqReady); end
    if1.rspReady = 1'b0;
  endtask

  task automatic test_neg_offset;
    int rd_cnt;
    int first_v;
    store1(32'd32, 16'd0, 32'h1234_5678);
    rd_cnt = 0; first_v = 0;
    if3.rspReady = 1'b0;
    if3.reqValid = 1'b1; if3.reqWrite = 1'b0; if3.reqBase = 32'd40; if3.reqOffset = 16'hFFF8;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) if3.reqValid = 1'b0;
      if (if3.memRead) rd_cnt++;
      if (if3.rspValid && first_v == 0) first_v = c;
    end
    n_cmp++;
    if (if3.memAddr !== 32'd8) begin n_bad++; $display("FAIL neg_addr got %0d exp 8", if3.memAddr); end
    n_cmp++;
    if (rd_cnt !== 3) begin n_bad++; $display("FAIL neg_rdcycles got %0d exp 3", rd_cnt); end
    n_cmp++;
    if (first_v !== 4) begin n_bad++; $display("FAIL neg_rspcycle got %0d exp 4", first_v); end
    n_cmp++;
    if (if3.rspData !== 32'h1234_5678) begin n_bad++; $display("FAIL neg_data got %h exp 12345678", if3.rspData); end
    if3.rspReady = 1'b1;
    @(negedge clk);
    if3.rspReady = 1'b0;
  endtask

  task automatic test_errors;
    if1.rspReady = 1'b0;
    issue1(1'b0, 32'd6, 16'd0, 32'd0);
    n_cmp++;
    if ({if1.rspValid, if1.rspError, if1.memRead, if1.memWrite} !== 4'b1100 || if1.rspData !== 32'd0) begin
      n_bad++; $display("FAIL err_misalign got v%b e%b r%b w%b d%h exp v1 e1 r0 w0 d0",
        if1.rspValid, if1.rspError, if1.memRead, if1.memWrite, if1.rspData);
    end
    if1.rspReady = 1'b1; @(negedge clk); if1.rspReady = 1'b0;
    issue1(1'b1, 32'd1024, 16'd0, 32'h5555_5555);
    n_cmp++;
    if ({if1.rspValid, if1.rspError, if1.memRead, if1.memWrite} !== 4'b1100 || if1.rspData !== 32'd0) begin
      n_bad++; $display("FAIL err_range got v%b e%b r%b w%b d%h exp v1 e1 r0 w0 d0",
        if1.rspValid, if1.rspError, if1.memRead, if1.memWrite, if1.rspData);
    end
    if1.rspReady = 1'b1; @(negedge clk); if1.rspReady = 1'b0;
    // 4 + (-8) wraps to 0xFFFFFFFC: aligned but far out of range.
    issue1(1'b0, 32'd4, 16'hFFF8, 32'd0);
    n_cmp++;
    if ({if1.rspValid, if1.rspError, if1.memRead} !== 3'b110) begin
      n_bad++; $display("FAIL err_wrap got %b exp 110", {if1.rspValid, if1.rspError, if1.memRead});
    end
    if1.rspReady = 1'b1; @(negedge clk); if1.rspReady = 1'b0;
    // Last legal word.
    issue1(1'b0, 32'd1020, 16'd0, 32'd0);
    n_cmp++;
    if (if1.memRead !== 1'b1 || if1.memAddr !== 32'd255) begin
      n_bad++; $display("FAIL edge_addr got r%b addr %0d exp r1 addr 255", if1.memRead, if1.memAddr);
    end
    @(negedge clk);
    n_cmp++;
    if ({if1.rspValid, if1.rspError} !== 2'b10) begin
      n_bad++; $display("FAIL edge_rsp got %b exp 10", {if1.rspValid, if1.rspError});
    end
    if1.rspReady = 1'b1; @(negedge clk); if1.rspReady = 1'b0;
  endtask

  task automatic test_backpressure;
    store1(32'd12, 16'd0, 32'hDEAD_BEEF);
    if1.rspReady = 1'b0;
    issue1(1'b0, 32'd12, 16'd0, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({if1.rspValid, if1.reqReady} !== 2'b10 || if1.rspData !== 32'hDEAD_BEEF) begin
        n_bad++; $display("FAIL bp_hold cycle %0d got v%b rdy%b d%h exp v1 rdy0 dDEADBEEF",
          i, if1.rspValid, if1.reqReady, if1.rspData);
      end
      @(negedge clk);
    end
    if1.rspReady = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({if1.rspValid, if1.reqReady} !== 2'b01) begin
      n_bad++; $display("FAIL bp_done got %b exp 01", {if1.rspValid, if1.reqReady});
    end
    if1.rspReady = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    int seen;
    int rd_cnt;
    int first_v;
    if4.rspReady = 1'b0;
    if4.reqValid = 1'b1; if4.reqWrite = 1'b0; if4.reqBase = 32'd20; if4.reqOffset = 16'd0;
    @(posedge clk);
    @(negedge clk);
    if4.reqValid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (if4.memRead !== 1'b1) begin n_bad++; $display("FAIL mid_pre got %b exp 1", if4.memRead); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if4.memRead, if4.rspValid} !== 2'b00) begin
      n_bad++; $display("FAIL mid_async got %b exp 00", {if4.memRead, if4.rspValid});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if4.rspValid) seen = 1;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL mid_norsp got %0d exp 0", seen); end
    rd_cnt = 0; first_v = 0;
    if4.rspReady = 1'b0;
    if4.reqValid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) if4.reqValid = 1'b0;
      if (if4.memRead) rd_cnt++;
      if (if4.rspValid && first_v == 0) first_v = c;
    end
    n_cmp++;
    if (rd_cnt !== 4 || first_v !== 5) begin
      n_bad++; $display("FAIL mid_after got rd %0d v@%0d exp rd 4 v@5", rd_cnt, first_v);
    end
    n_cmp++;
    if (if4.rspData !== 32'd99) begin n_bad++; $display("FAIL mid_data got %0d exp 99", if4.rspData); end
    if4.rspReady = 1'b1;
    @(negedge clk);
    if4.rspReady = 1'b0;
  endtask

  initial begin
    if1.reqValid = 1'b0; if1.reqWrite = 1'b0; if1.reqBase = '0; if1.reqOffset = '0;
    if1.reqWData = '0; if1.rspReady = 1'b0;
    if3.reqValid = 1'b0; if3.reqWrite = 1'b0; if3.reqBase = '0; if3.reqOffset = '0;
    if3.reqWData = '0; if3.rspReady = 1'b0;
    if4.reqValid = 1'b0; if4.reqWrite = 1'b0; if4.reqBase = '0; if4.reqOffset = '0;
    if4.reqWData = '0; if4.rspReady = 1'b0;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_neg_offset();
    test_errors();
    test_backpressure();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the single-cycle datapath. It accepts one word-access request per transaction from the execute stage: base register value, signed 16-bit offset, write flag and store data. It forms and checks the effective address, then drives the data RAM's read/write-strobe interface. It waits the RAM's read latency and returns the loaded word, or a completion for stores, over a valid/ready response channel. It is the requesting end of the `memRead`/`memWrite`/address/data port the RAM responds on.

## Interface
- `MEM_WORDS`, 256: number of 32-bit words in the attached RAM; word index must be < MEM_WORDS.
- `READ_LATENCY`, 1: cycles `memRead` is held before `memRData` is sampled; legal 1..15.

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  unit can accept a request.
- `reqWrite`  in  1  1 = store (sw), 0 = load (lw).
- `reqBase`  in  32  base byte address (rs value).
- `reqOffset`  in  16  signed byte offset (immediate).
- `reqWData`  in  32  store data (rt value).
- `rspValid`  out  1  response present.
- `rspReady`  in  1  consumer takes response.
- `rspData`  out  32  loaded word; 0 for stores and errors.
- `rspError`  out  1  misaligned or out-of-range address.
- `memRead`  out  1  RAM read strobe.
- `memWrite`  out  1  RAM write strobe.
- `memAddr`  out  32  RAM word index, zero-extended.
- `memWData`  out  32  RAM write data.
- `memRData`  in  32  RAM read data.

## Operation
- Effective byte address is `ea = reqBase + signext(reqOffset)`, mod 2^32; wrap-around is not an error by itself.
- Error if `ea[1:0] != 0`, or if `ea >> 2 >= MEM_WORDS`. An errored request never asserts `memRead`/`memWrite`.
- States: IDLE, READ, WRITE, RESP.
- **IDLE:** `reqReady` = 1. On `reqValid && reqReady`, capture the request and register `memAddr = ea >> 2` and `memWData = reqWData`.
  - If the request errors: next state RESP with `rspError` = 1 and `rspData` = 0.
  - Else if `reqWrite`: WRITE.
  - Else: READ with the latency counter cleared.
- **WRITE:** `memWrite` = 1 for exactly one cycle, then RESP with `rspData` = 0 and `rspError` = 0.
- **READ:** `memRead` = 1 every cycle in this state. The counter increments each edge. At the edge where counter == READ_LATENCY-1, capture `memRData` into `rspData` and go to RESP.
- **RESP:** `rspValid` = 1. `rspData` and `rspError` hold stable until `rspValid && rspReady`, then IDLE.
- `reqReady` = 0 in every state but IDLE; only one transaction is outstanding.
- `memAddr`/`memWData` hold their last captured value between transactions.
- `memRead` and `memWrite` are never high together, and are 0 outside READ/WRITE.

## Timing
- Reset values while `rst_n` = 0: state IDLE, `reqReady` 0, `rspValid` 0, `rspData` 0, `rspError` 0, `memRead` 0, `memWrite` 0, `memAddr` 0, `memWData` 0.
- `reqReady` is a register. It rises at the first `clk` edge after `rst_n` deasserts.
- Accept edge is E0:
  - Load: `memRead` high for cycles E0+1 .. E0+L, where L = READ_LATENCY. Data is sampled at edge E0+L. `rspValid` is high from cycle E0+L+1.
  - Store: `memWrite` high in cycle E0+1 only. `rspValid` is high from cycle E0+2.
  - Error: `rspValid` is high from cycle E0+1, with no strobes.
- The response handshake at edge E1 returns the unit to IDLE. `reqReady` = 1 from E1, so the next accept is possible at E1+1.
  - Back-to-back loads at L=1 complete one per 3 cycles.
- `rspReady` held high before `rspValid` means the response completes on its first valid cycle.
- Reset asserted mid-transaction:
  - Strobes and `rspValid` drop immediately (asynchronously).
  - The pending transaction is discarded and no response is produced.
  - RAM state written before reset is not undone.

## Test plan
- **Reset:** `rst_n` low for 3 cycles with `reqValid` = 1 → all outputs 0, no accept. `reqReady` = 1 one edge after release.
- **Store then load:**
  - Store: `reqBase` = 16, `reqOffset` = 4, `reqWData` = 99 → `memWrite` for one cycle with `memAddr` = 5 and `memWData` = 99; `rspData` = 0, `rspError` = 0.
  - Load: same address (`reqBase` = 16, `reqOffset` = 4) → `memRead` with `memAddr` = 5; `rspData` = 99, `rspValid` 2 cycles after accept at L = 1.
- **Negative offset and latency:** L = 3, `reqBase` = 40, `reqOffset` = 0xFFF8 (−8) → `memAddr` = 8, `memRead` high exactly 3 cycles, `rspValid` at E0+4.
- **Errors, no strobes:**
  - `reqBase` = 6, `reqOffset` = 0 (misaligned) → `rspError` = 1, `rspData` = 0, `rspValid` at E0+1.
  - `reqBase` = 1024, `reqOffset` = 0 with MEM_WORDS = 256 (out of range) → `rspError` = 1.
- **Backpressure:** `rspReady` held 0 for 5 cycles after a load returning 0xDEADBEEF → `rspValid`/`rspData` stable for all 5 cycles, `reqReady` = 0 throughout. Completes on the cycle `rspReady` = 1.
- **Reset mid-read:** L = 4, `rst_n` pulsed low during the second `memRead` cycle → `memRead` drops immediately, no `rspValid` ever appears. The next request after release completes normally.
